// File: rtl/reg_file_pkg.sv
// Shared types and constants for the architectural integer register file.
// Configuration macro used by this block: REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int DEFAULT_PEND_WIDTH     = 2;

    localparam int NUM_REGS = 2 ** DEFAULT_REG_ADDR_WIDTH;
    localparam int PEND_MAX = (2 ** DEFAULT_PEND_WIDTH) - 1;

    typedef logic [DEFAULT_DATA_WIDTH-1:0]     word_t;
    typedef logic [DEFAULT_REG_ADDR_WIDTH-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_pending_ctr.sv
// Per-register pending-write counter: claims count up, writeback releases count down.
// With REG_FILE_BYPASS_EN defined, busy reflects the count after a same-cycle release.
module reg_pending_ctr #(
    parameter int PEND_WIDTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic at_max
);

    localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] CNT_ONE = PEND_WIDTH'(1);

    logic [PEND_WIDTH-1:0] count_reg;
    logic [PEND_WIDTH-1:0] count_next;

    // A claim and a release landing together cancel out.
    always_comb begin
        count_next = count_reg;
        if (inc && !dec && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_ONE;
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign at_max = (count_reg == CNT_MAX);

`ifdef REG_FILE_BYPASS_EN
    assign busy = (count_reg != '0) && !(dec && (count_reg == CNT_ONE));
`else
    assign busy = (count_reg != '0);
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file with two combinational read ports, one write port and a
// pending-write scoreboard. REG_FILE_BYPASS_EN enables same-cycle write-through.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int PEND_WIDTH     = DEFAULT_PEND_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      claim_valid,
    input  logic [REG_ADDR_WIDTH-1:0] claim_addr,
    output logic                      claim_ready,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data
);

    localparam int N_REGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [N_REGS];
    logic [N_REGS-1:0]     busy_vec;
    logic [N_REGS-1:0]     at_max_vec;
    logic                  wr_nonzero;
    logic                  claim_fire;

    assign wr_nonzero = we && (wr_addr != '0);

    // Storage stays in flops: the whole array must clear on an asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_nonzero) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    // x0 never holds a claim, so it is never busy and never full.
    assign busy_vec[0]   = 1'b0;
    assign at_max_vec[0] = 1'b0;

    // Readiness uses the pre-release count, so a full register refuses even during a release.
    assign claim_ready = !at_max_vec[claim_addr];
    assign claim_fire  = claim_valid && claim_ready;

    generate
        for (genvar gi = 1; gi < N_REGS; gi++) begin : g_pend
            logic inc;
            logic dec;

            assign inc = claim_fire && (claim_addr == REG_ADDR_WIDTH'(gi));
            assign dec = we && (wr_addr == REG_ADDR_WIDTH'(gi));

            reg_pending_ctr #(
                .PEND_WIDTH (PEND_WIDTH)
            ) u_ctr (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc    (inc),
                .dec    (dec),
                .busy   (busy_vec[gi]),
                .at_max (at_max_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        rs1_data = regs_reg[rs1_addr];
        rs2_data = regs_reg[rs2_addr];
`ifdef REG_FILE_BYPASS_EN
        if (wr_nonzero && (rs1_addr == wr_addr)) begin
            rs1_data = wr_data;
        end
        if (wr_nonzero && (rs2_addr == wr_addr)) begin
            rs2_data = wr_data;
        end
`endif
    end

    assign rs1_busy = busy_vec[rs1_addr];
    assign rs2_busy = busy_vec[rs2_addr];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations adapt to REG_FILE_BYPASS_EN.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        claim_valid;
    logic [4:0]  claim_addr;
    logic        claim_ready;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int errors = 0;
    int checks = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .claim_ready (claim_ready),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; rs1_addr = '0; rs2_addr = '0;
        claim_valid = 1'b0; claim_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        #2 rst_n = 1'b0;
        #1;
        // Reset state on every register through both ports.
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); claim_addr = 5'(i);
            #1;
            chk($sformatf("rst_rs1_data[%0d]", i), rs1_data, 32'h0);
            chk($sformatf("rst_rs2_data[%0d]", i), rs2_data, 32'h0);
            chk($sformatf("rst_busy[%0d]", i), {30'h0, rs1_busy, rs2_busy}, 32'h0);
            chk($sformatf("rst_claim_ready[%0d]", i), {31'h0, claim_ready}, 32'h1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        $display("txn reset: all registers zero, idle");

        // Write x5 while reading it in the same cycle.
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1 chk("x5_same_cycle", rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
        step();
        we = 1'b0;
        #1 chk("x5_next_cycle", rs1_data, 32'hDEADBEEF);
        $display("txn write x5=deadbeef");

        // x0: writes discarded, claims accepted without effect.
        rs1_addr = 5'd0; claim_valid = 1'b1; claim_addr = 5'd0;
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("x0_data[%0d]", k), rs1_data, 32'h0);
            chk($sformatf("x0_busy[%0d]", k), {31'h0, rs1_busy}, 32'h0);
            chk($sformatf("x0_ready[%0d]", k), {31'h0, claim_ready}, 32'h1);
            step();
        end
        claim_valid = 1'b0; we = 1'b0;
        #1 chk("x0_data_after", rs1_data, 32'h0);
        $display("txn x0 write+4 claims ignored");

        // Fill x7 to its maximum of three outstanding claims.
        rs2_addr = 5'd7; claim_addr = 5'd7; claim_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("x7_claim_ready[%0d]", k), {31'h0, claim_ready}, 32'h1);
            step();
        end
        #1;
        chk("x7_full_busy", {31'h0, rs2_busy}, 32'h1);
        chk("x7_full_ready", {31'h0, claim_ready}, 32'h0);
        step();
        claim_valid = 1'b0;
        #1 chk("x7_refused_no_wrap", {31'h0, claim_ready}, 32'h0);
        $display("txn claim x7 x3, full");

        // Release x7; the first release coincides with a claim that must be refused.
        claim_valid = 1'b1; we = 1'b1; wr_addr = 5'd7; wr_data = 32'h70;
        #1;
        chk("x7_full_release_ready", {31'h0, claim_ready}, 32'h0);
        chk("x7_rel1_busy_pre", {31'h0, rs2_busy}, 32'h1);
        step();
        claim_valid = 1'b0; wr_data = 32'h71;
        #1;
        chk("x7_rel1_ready", {31'h0, claim_ready}, 32'h1);
        chk("x7_rel1_busy", {31'h0, rs2_busy}, 32'h1);
        chk("x7_rel1_data", rs2_data, BYP ? 32'h71 : 32'h70);
        step();
        wr_data = 32'h72;
        #1 chk("x7_rel3_busy_pre", {31'h0, rs2_busy}, BYP ? 32'h0 : 32'h1);
        step();
        we = 1'b0;
        #1;
        chk("x7_rel3_busy", {31'h0, rs2_busy}, 32'h0);
        chk("x7_rel3_data", rs2_data, 32'h72);
        $display("txn release x7 x3, refused claim at max");

        // Claim x8 and write x5 in the same cycle: independent updates.
        rs1_addr = 5'd8; rs2_addr = 5'd5;
        claim_valid = 1'b1; claim_addr = 5'd8; we = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
        step();
        claim_valid = 1'b0; we = 1'b0;
        #1;
        chk("x8_busy", {31'h0, rs1_busy}, 32'h1);
        chk("x5_data_indep", rs2_data, 32'h55);
        chk("x5_busy_indep", {31'h0, rs2_busy}, 32'h0);
        $display("txn claim x8 + write x5=55");

        // x3: claim once, then claim+write together leaves pend at 1.
        rs1_addr = 5'd3; claim_valid = 1'b1; claim_addr = 5'd3;
        step();
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h12;
        #1 chk("x3_sim_ready", {31'h0, claim_ready}, 32'h1);
        step();
        claim_valid = 1'b0; we = 1'b0;
        #1;
        chk("x3_sim_busy", {31'h0, rs1_busy}, 32'h1);
        chk("x3_sim_data", rs1_data, 32'h12);
        we = 1'b1; wr_data = 32'h13;
        step();
        wr_data = 32'h34;
        #1 chk("x3_released_busy", {31'h0, rs1_busy}, 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("x3_pend0_data", rs1_data, 32'h34);
        chk("x3_pend0_busy", {31'h0, rs1_busy}, 32'h0);
        $display("txn x3 claim+write same cycle, write at pend0");

        // x9 = 0xAA with two claims, then an asynchronous reset mid-cycle.
        rs1_addr = 5'd9; we = 1'b1; wr_addr = 5'd9; wr_data = 32'hAA;
        step();
        we = 1'b0; claim_valid = 1'b1; claim_addr = 5'd9;
        step();
        step();
        claim_valid = 1'b0;
        #1;
        chk("x9_pre_rst_data", rs1_data, 32'hAA);
        chk("x9_pre_rst_busy", {31'h0, rs1_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("x9_rst_data", rs1_data, 32'h0);
        chk("x9_rst_busy", {31'h0, rs1_busy}, 32'h0);
        chk("x9_rst_ready", {31'h0, claim_ready}, 32'h1);
        rst_n = 1'b1;
        #1 chk("x5_rst_data", {rs1_data[31:8], 8'h0} | (rs1_addr == 5'd9 ? 32'h0 : 32'h1), 32'h0);
        // A late writeback after reset is a plain write; one claim must leave room for more.
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'hBB;
        step();
        we = 1'b0; claim_valid = 1'b1;
        step();
        claim_valid = 1'b0;
        #1;
        chk("x9_post_rst_data", rs1_data, 32'hBB);
        chk("x9_post_rst_busy", {31'h0, rs1_busy}, 32'h1);
        chk("x9_post_rst_ready", {31'h0, claim_ready}, 32'h1);
        $display("txn x9 async reset mid-cycle, late writeback");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
